bcd_updown_counter: RTL and testbench
=====================================

BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 Parameter DIGITS, default 2: number of BCD digits; legal range 1..8; W = 4*DIGITS.
REQ-002 Parameter RST_VAL, default all-zero, width W: BCD value loaded by reset.
REQ-003 clk  input  1  single global clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 en  input  1  count enable; one step per cycle when high.
REQ-006 dir  input  1  count direction; 1 = up, 0 = down.
REQ-007 load  input  1  synchronous load strobe.
REQ-008 load_val  input  W  BCD value for load.
REQ-009 max_val  input  W  BCD upper bound.
REQ-010 min_val  input  W  BCD lower bound; max_val >= min_val by contract.
REQ-011 cnt  output  W  registered BCD count; digit k at bits [4k+3:4k].
REQ-012 cout  output  1  registered one-cycle pulse on up-wrap or up-overflow attempt.
REQ-013 bout  output  1  registered one-cycle pulse on down-wrap or down-underflow attempt.
REQ-014 tc  output  1  combinational terminal count: (dir & cnt==max_val) | (~dir & cnt==min_val); used for cascading.
REQ-015 load_err  output  1  registered one-cycle pulse when the applied load_val contained a digit >9.

Function
REQ-016 Priority per cycle SHALL be load > en > hold.
REQ-017 load=1: cnt SHALL take load_val next cycle, with any digit >9 replaced by 9; load_err SHALL pulse iff a digit was replaced; cout/bout SHALL be 0.
REQ-018 en=1, dir=1, cnt<max_val: cnt SHALL increment by one in BCD; each digit wraps 9->0 and carries into the next digit in the same cycle.
REQ-019 en=1, dir=0, cnt>min_val: cnt SHALL decrement by one in BCD; each digit wraps 0->9 and borrows from the next digit in the same cycle.
REQ-020 en=1, dir=1, cnt>=max_val: cnt SHALL wrap to min_val and cout SHALL be 1 next cycle (see REQ-031).
REQ-021 en=1, dir=0, cnt<=min_val: cnt SHALL wrap to max_val and bout SHALL be 1 next cycle (see REQ-031).
REQ-022 Comparisons SHALL be unsigned on the whole W-bit word; BCD ordering equals binary ordering for valid BCD.
REQ-023 en=0 and load=0: cnt SHALL hold; cout, bout and load_err SHALL be 0.
REQ-024 cout, bout and load_err SHALL never be high for more than one cycle per causing event, and cout and bout SHALL never be high together.
REQ-025 Latency SHALL be one cycle from input to cnt/cout/bout/load_err; tc SHALL have zero latency.
REQ-026 A change of max_val/min_val while cnt lies outside [min_val,max_val] SHALL NOT by itself alter cnt; the next enabled step applies REQ-020/021.
REQ-027 max_val==min_val: every enabled step SHALL leave cnt at that value and pulse cout (up) or bout (down).

Reset
REQ-028 rst=0 SHALL immediately force cnt=RST_VAL, cout=0, bout=0, load_err=0, regardless of clk.
REQ-029 Reset asserted mid-count or mid-load SHALL discard the pending operation; the first edge after release SHALL see cnt=RST_VAL.

Configuration
REQ-030 Macro BCD_CNT_SAT_EN selects the boundary mode.
REQ-031 BCD_CNT_SAT_EN defined: at REQ-020/021 conditions cnt SHALL hold at max_val (up) or min_val (down), clamping to the bound if outside it; cout/bout SHALL still pulse every enabled cycle at the bound.
REQ-032 BCD_CNT_SAT_EN undefined: wrap behaviour per REQ-020/021; the port list SHALL be identical in both builds.

Verification (DIGITS=2, RST_VAL=00, min_val=00, max_val=59)
REQ-033 rst low mid-count at cnt=37 -> cnt=00, cout=bout=load_err=0 without waiting for clk.
REQ-034 load 58, then en=1, dir=1 for 3 cycles -> cnt 59, 00, 01; cout=1 only in the cycle cnt shows 00.
REQ-035 load 10, then en=1, dir=0 for 12 cycles -> cnt 09 ... 00, 59, 58; bout=1 only in the cycle cnt shows 59; tc=1 while cnt=00.
REQ-036 load and en both high with load_val=0xA7 -> cnt=97, load_err=1 one cycle, no count step, cout=0.
REQ-037 BCD_CNT_SAT_EN build: cnt=59, en=1, dir=1 for 3 cycles -> cnt stays 59, cout=1 each cycle; dir=0 at cnt=00 -> stays 00, bout=1.
REQ-038 max_val lowered to 30 while cnt=45, en=0 -> cnt stays 45; then en=1, dir=1 -> cnt=00, cout=1 (wrap build).

Source files
------------

// File: rtl/bcd_updown_counter.sv
// BCD up/down counter with bounds, load clamping and cascade terminal count.
// Define BCD_CNT_SAT_EN to saturate at the bounds instead of wrapping.
module bcd_updown_counter #(
  parameter int                  DIGITS  = 2,
  parameter logic [4*DIGITS-1:0] RST_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic [4*DIGITS-1:0]   max_val,
  input  logic [4*DIGITS-1:0]   min_val,
  output logic [4*DIGITS-1:0]   cnt,
  output logic                  cout,
  output logic                  bout,
  output logic                  tc,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] cnt_nxt;
  logic         cout_nxt;
  logic         bout_nxt;
  logic         err_nxt;
  logic [W-1:0] load_fix;
  logic         load_bad;

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    logic [3:0]   d;
    r = v;
    c = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      d = v[4*k +: 4];
      if (c) begin
        if (d == 4'd9) begin
          d = 4'd0;
        end else begin
          d = d + 4'd1;
          c = 1'b0;
        end
      end
      r[4*k +: 4] = d;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    logic [3:0]   d;
    r = v;
    b = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      d = v[4*k +: 4];
      if (b) begin
        if (d == 4'd0) begin
          d = 4'd9;
        end else begin
          d = d - 4'd1;
          b = 1'b0;
        end
      end
      r[4*k +: 4] = d;
    end
    return r;
  endfunction

  // Clamp each load digit to 9 and flag any that needed it
  always_comb begin
    load_fix = load_val;
    load_bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (load_val[4*k +: 4] > 4'd9) begin
        load_fix[4*k +: 4] = 4'd9;
        load_bad           = 1'b1;
      end
    end
  end

  // Next count and flag pulses: load beats enable beats hold
  always_comb begin
    cnt_nxt  = cnt;
    cout_nxt = 1'b0;
    bout_nxt = 1'b0;
    err_nxt  = 1'b0;
    if (load) begin
      cnt_nxt = load_fix;
      err_nxt = load_bad;
    end else if (en) begin
      if (dir) begin
        if (cnt < max_val) begin
          cnt_nxt = bcd_inc(cnt);
        end else begin
          cout_nxt = 1'b1;
`ifdef BCD_CNT_SAT_EN
          cnt_nxt  = max_val;
`else
          cnt_nxt  = min_val;
`endif
        end
      end else begin
        if (cnt > min_val) begin
          cnt_nxt = bcd_dec(cnt);
        end else begin
          bout_nxt = 1'b1;
`ifdef BCD_CNT_SAT_EN
          cnt_nxt  = min_val;
`else
          cnt_nxt  = max_val;
`endif
        end
      end
    end
  end

  // Count and pulse registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= RST_VAL;
      cout     <= 1'b0;
      bout     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      cout     <= cout_nxt;
      bout     <= bout_nxt;
      load_err <= err_nxt;
    end
  end

  // Terminal count for cascading, zero latency
  always_comb begin
    tc = (dir & (cnt == max_val)) | (~dir & (cnt == min_val));
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench for bcd_updown_counter (DIGITS=2).
// Decimal reference model; directed cases then random traffic.
module tb_bcd_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       dir = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = '0;
  logic [7:0] max_val = 8'h59;
  logic [7:0] min_val = 8'h00;
  logic [7:0] cnt;
  logic       cout;
  logic       bout;
  logic       tc;
  logic       load_err;

  bcd_updown_counter #(.DIGITS(2), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
    .load_val(load_val), .max_val(max_val), .min_val(min_val),
    .cnt(cnt), .cout(cout), .bout(bout), .tc(tc), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cnt;
    logic       cout;
    logic       bout;
    logic       err;
    logic       tc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   m  = 0;
  int   mx = 59;
  int   mn = 0;

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic step(input bit l, input logic [7:0] lv,
                      input bit e, input bit d);
    exp_t x;
    int   hi;
    int   lo;
    @(negedge clk);
    load     = l;
    load_val = lv;
    en       = e;
    dir      = d;
    max_val  = to_bcd(mx);
    min_val  = to_bcd(mn);
    x.cout = 1'b0;
    x.bout = 1'b0;
    x.err  = 1'b0;
    if (l) begin
      hi    = int'(lv[7:4]);
      lo    = int'(lv[3:0]);
      x.err = (hi > 9) || (lo > 9);
      m     = (hi > 9 ? 9 : hi) * 10 + (lo > 9 ? 9 : lo);
    end else if (e) begin
      if (d) begin
        if (m < mx) m = m + 1;
        else begin
          x.cout = 1'b1;
`ifdef BCD_CNT_SAT_EN
          m = mx;
`else
          m = mn;
`endif
        end
      end else begin
        if (m > mn) m = m - 1;
        else begin
          x.bout = 1'b1;
`ifdef BCD_CNT_SAT_EN
          m = mn;
`else
          m = mx;
`endif
        end
      end
    end
    x.cnt = to_bcd(m);
    x.tc  = d ? (m == mx) : (m == mn);
    q.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    en   = 1'b0;
    load = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_rst_cnt", cnt, 8'h00);
    chk("async_rst_flags", {5'd0, cout, bout, load_err}, 8'h00);
    m = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: compare DUT against queued expectations after each edge
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("cnt", cnt, x.cnt);
        chk("cout", {7'd0, cout}, {7'd0, x.cout});
        chk("bout", {7'd0, bout}, {7'd0, x.bout});
        chk("load_err", {7'd0, load_err}, {7'd0, x.err});
        chk("tc", {7'd0, tc}, {7'd0, x.tc});
      end
    end
  end

  initial begin
    int a;
    int b;
    logic [7:0] lv;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    // mid-count reset at 37
    step(1'b1, 8'h36, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    do_reset();
    // up across the wrap
    step(1'b1, 8'h58, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b1);
    // down across the wrap
    step(1'b1, 8'h10, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    // invalid digit load with en high
    step(1'b1, 8'hA7, 1'b1, 1'b1);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    // lowered bound while outside range
    step(1'b1, 8'h45, 1'b0, 1'b1);
    mx = 30;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    // equal bounds
    mx = 59;
    mn = 59;
    step(1'b1, 8'h59, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    mn = 0;
    // random traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        a  = $urandom_range(0, 99);
        b  = $urandom_range(0, 99);
        mn = a < b ? a : b;
        mx = a < b ? b : a;
      end
      if ($urandom_range(0, 199) == 0) begin
        while (q.size() > 0) @(posedge clk);
        do_reset();
      end
      if ($urandom_range(0, 3) == 0) lv = 8'($urandom);
      else lv = to_bcd($urandom_range(0, 99));
      step($urandom_range(0, 9) == 0, lv,
           $urandom_range(0, 3) != 0, 1'($urandom));
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
